// File: rtl/muldiv_unit_if.sv
// Operand/request and writeback bundle between the register file side and muldiv_unit.
interface muldiv_unit_if #(parameter int WIDTH = 16);
    logic             start;
    logic             op;
    logic [2:0]       dest_adr;
    logic [WIDTH-1:0] R;
    logic [WIDTH-1:0] S;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] W;
    logic [2:0]       W_Adr;
    logic             we;
    logic [WIDTH-1:0] HI;
    logic             div0;

    modport master (
        output start, op, dest_adr, R, S,
        input  busy, done, W, W_Adr, we, HI, div0
    );

    modport slave (
        input  start, op, dest_adr, R, S,
        output busy, done, W, W_Adr, we, HI, div0
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 16-bit unsigned shift-add multiplier / restoring divider with a
// one-cycle register-file writeback; the high word or remainder lands in HI.
module muldiv_unit #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] acc_hi, acc_lo, opb;
    logic [WIDTH-1:0] iter_hi, iter_lo;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             op_q, div0_flag, last_iter, accept;
    logic [2:0]       adr_q;
    logic [3:0]       count;

    assign accept    = (state == IDLE) && bus.start;
    assign last_iter = (state == RUN) && (count == 4'(ITER - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (count == 4'(ITER - 1)) next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Multiply keeps the multiplier in acc_lo and shifts the product in from the top;
    // divide shifts the dividend out of acc_lo into the partial remainder in acc_hi.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        iter_hi   = mul_sum[WIDTH:1];
        iter_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (op_q) begin
            if (!div_diff[WIDTH+1]) begin
                iter_hi = div_diff[WIDTH-1:0];
                iter_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                iter_hi = div_shift[WIDTH-1:0];
                iter_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // A zero divisor needs no special path: every trial subtract succeeds,
    // giving an all-ones quotient and the dividend as remainder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_hi    <= '0;
            acc_lo    <= '0;
            opb       <= '0;
            op_q      <= 1'b0;
            adr_q     <= '0;
            count     <= '0;
            div0_flag <= 1'b0;
        end else if (accept) begin
            acc_hi    <= '0;
            acc_lo    <= bus.R;
            opb       <= bus.S;
            op_q      <= bus.op;
            adr_q     <= bus.dest_adr;
            count     <= '0;
            div0_flag <= bus.op && (bus.S == '0);
        end else if (state == RUN) begin
            acc_hi    <= iter_hi;
            acc_lo    <= iter_lo;
            count     <= count + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.we    <= 1'b0;
            bus.div0  <= 1'b0;
            bus.W     <= '0;
            bus.W_Adr <= '0;
            bus.HI    <= '0;
        end else begin
            bus.busy <= (next_state != IDLE);
            bus.done <= last_iter;
            bus.we   <= last_iter;
            if (accept) bus.div0 <= 1'b0;
            if (last_iter) begin
                bus.W     <= iter_lo;
                bus.HI    <= iter_hi;
                bus.W_Adr <= adr_q;
                bus.div0  <= div0_flag;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: exact-latency writeback checks for multiply,
// divide, divide-by-zero, ignored starts and mid-operation reset.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic saw_activity;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Operands are scrambled right after the accept edge; the result must not see it.
    task automatic apply_stimulus(input logic op, input logic [15:0] r, input logic [15:0] s, input logic [2:0] adr);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.R        = r;
        bus.S        = s;
        bus.dest_adr = adr;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.op       = ~op;
        bus.R        = ~r;
        bus.S        = ~s;
        bus.dest_adr = ~adr;
    endtask

    task automatic run_op(input string tag, input logic op, input logic [15:0] r, input logic [15:0] s,
                          input logic [2:0] adr, input logic [15:0] exp_w, input logic [15:0] exp_hi,
                          input logic exp_div0);
        apply_stimulus(op, r, s, adr);
        check_output({tag, "/busy_accept"}, 32'(bus.busy), 32'd1);
        check_output({tag, "/div0_accept"}, 32'(bus.div0), 32'd0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check_output({tag, "/we_early"}, 32'(bus.we), 32'd0);
        @(negedge clk);
        check_output({tag, "/we"}, 32'(bus.we), 32'd1);
        check_output({tag, "/done"}, 32'(bus.done), 32'd1);
        check_output({tag, "/W"}, 32'(bus.W), 32'(exp_w));
        check_output({tag, "/W_Adr"}, 32'(bus.W_Adr), 32'(adr));
        check_output({tag, "/HI"}, 32'(bus.HI), 32'(exp_hi));
        check_output({tag, "/div0"}, 32'(bus.div0), 32'(exp_div0));
        check_output({tag, "/busy_wb"}, 32'(bus.busy), 32'd1);
        @(negedge clk);
        check_output({tag, "/we_after"}, 32'(bus.we), 32'd0);
        check_output({tag, "/done_after"}, 32'(bus.done), 32'd0);
        check_output({tag, "/busy_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 1'b0;
        bus.R        = '0;
        bus.S        = '0;
        bus.dest_adr = '0;
        #12;
        check_output("reset/busy", 32'(bus.busy), 32'd0);
        check_output("reset/we", 32'(bus.we), 32'd0);
        check_output("reset/done", 32'(bus.done), 32'd0);
        check_output("reset/W", 32'(bus.W), 32'd0);
        check_output("reset/HI", 32'(bus.HI), 32'd0);
        check_output("reset/div0", 32'(bus.div0), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op("mul7x6", 1'b0, 16'h0007, 16'h0006, 3'd3, 16'h002A, 16'h0000, 1'b0);
        run_op("mulmax", 1'b0, 16'hFFFF, 16'hFFFF, 3'd7, 16'h0001, 16'hFFFE, 1'b0);
        run_op("mul_adr0", 1'b0, 16'h1234, 16'h0010, 3'd0, 16'h2340, 16'h0001, 1'b0);
        run_op("div100_7", 1'b1, 16'h0064, 16'h0007, 3'd2, 16'h000E, 16'h0002, 1'b0);
        run_op("div_max1", 1'b1, 16'hFFFF, 16'h0001, 3'd4, 16'hFFFF, 16'h0000, 1'b0);
        run_op("div0", 1'b1, 16'h1234, 16'h0000, 3'd5, 16'hFFFF, 16'h1234, 1'b1);

        repeat (3) @(negedge clk);
        check_output("div0/held", 32'(bus.div0), 32'd1);
        check_output("div0/HI_held", 32'(bus.HI), 32'h1234);

        // Starts during RUN and during WB must both be ignored.
        apply_stimulus(1'b0, 16'h0003, 16'h0004, 3'd1);
        check_output("busy_start/div0_clr", 32'(bus.div0), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op       = 1'b1;
        bus.R        = 16'd9;
        bus.S        = 16'd3;
        bus.dest_adr = 3'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check_output("busy_start/we_early", 32'(bus.we), 32'd0);
        @(negedge clk);
        check_output("busy_start/we", 32'(bus.we), 32'd1);
        check_output("busy_start/W", 32'(bus.W), 32'h000C);
        check_output("busy_start/W_Adr", 32'(bus.W_Adr), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        saw_activity = 1'b0;
        repeat (20) begin
            saw_activity = saw_activity | bus.we | bus.busy;
            @(negedge clk);
        end
        check_output("busy_start/no_second_op", 32'(saw_activity), 32'd0);

        // Reset in RUN cycle 8 aborts with no writeback.
        apply_stimulus(1'b0, 16'h0100, 16'h0100, 3'd4);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("abort/we", 32'(bus.we), 32'd0);
        check_output("abort/done", 32'(bus.done), 32'd0);
        check_output("abort/busy", 32'(bus.busy), 32'd0);
        check_output("abort/W", 32'(bus.W), 32'd0);
        check_output("abort/W_Adr", 32'(bus.W_Adr), 32'd0);
        check_output("abort/HI", 32'(bus.HI), 32'd0);
        check_output("abort/div0", 32'(bus.div0), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("mul2x3", 1'b0, 16'h0002, 16'h0003, 3'd3, 16'h0006, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
